// File: rtl/bus_pkg.sv
// Shared datapath bus definitions: widths, destination codes and loader FSM states.
// The bus-side source encoder uses the same code constants.
package bus_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_DEST = 20;
  localparam int CODE_W   = 5;

  localparam logic [CODE_W-1:0]
    CODE_R0  = 5'd0,  CODE_R1  = 5'd1,  CODE_R2  = 5'd2,  CODE_R3  = 5'd3,
    CODE_R4  = 5'd4,  CODE_R5  = 5'd5,  CODE_R6  = 5'd6,  CODE_R7  = 5'd7,
    CODE_R8  = 5'd8,  CODE_R9  = 5'd9,  CODE_R10 = 5'd10, CODE_R11 = 5'd11,
    CODE_R12 = 5'd12, CODE_R13 = 5'd13, CODE_R14 = 5'd14, CODE_R15 = 5'd15,
    CODE_HI  = 5'd16, CODE_LO  = 5'd17, CODE_MAR = 5'd18, CODE_MDR = 5'd19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_WRITE = 2'd2
  } ldState_t;

endpackage

// File: rtl/dest_decoder_5to32.sv
// Combinational destination decoder: 5-bit code to one-hot strobes plus an in-range flag.
// Out-of-range codes produce an all-zero one-hot.
module dest_decoder_5to32
  import bus_pkg::*;
#(
  parameter int NUM_OUT = 32
) (
  input  logic [CODE_W-1:0]  code,
  output logic [NUM_OUT-1:0] onehot,
  output logic               inRange
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      onehot[i] = (code == CODE_W'(i));
    end
  end

  assign inRange = (32'(code) < 32'(NUM_OUT));

endmodule

// File: rtl/bus_dest_loader.sv
// Receiving end of the datapath bus: captures a destination code and bus word, decodes
// the code to registered Rin strobes and loads one register of the 20-entry bank.
module bus_dest_loader #(
  parameter int DATA_W   = bus_pkg::DATA_W,
  parameter int NUM_DEST = bus_pkg::NUM_DEST,
  parameter bit R0_ZERO  = 1'b0
) (
  input  logic                         clock,
  input  logic                         clear_n,
  // Request handshake: a load is accepted on a rising edge where ld_valid && ld_ready;
  // ld_ready is high only in IDLE, and the requester holds ld_valid/ld_code/bus_in until accepted.
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [bus_pkg::CODE_W-1:0]   ld_code,
  input  logic [DATA_W-1:0]            bus_in,
  output logic [NUM_DEST-1:0]          rin_onehot,
  output logic                         ld_done,
  output logic                         ld_err,
  output logic [NUM_DEST*DATA_W-1:0]   regs_flat,
  output bus_pkg::ldState_t            dbgState
);

  import bus_pkg::*;

  ldState_t            state, stateNext;
  logic [CODE_W-1:0]   codeQ;
  logic [DATA_W-1:0]   dataQ;
  logic                errPend;
  logic [NUM_DEST-1:0] decOnehot;
  logic                decInRange;
  logic                dropWrite;

  assign dbgState = state;

  always_ff @(posedge clock) begin
    if (!clear_n) state <= ST_IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    ld_ready  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) stateNext = ST_LATCH;
      end
      ST_LATCH: stateNext = ST_WRITE;
      ST_WRITE: stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  dest_decoder_5to32 #(
    .NUM_OUT (NUM_DEST)
  ) uDecoder (
    .code    (codeQ),
    .onehot  (decOnehot),
    .inRange (decInRange)
  );

  // A hardwired-zero R0 swallows its write without flagging an error.
  assign dropWrite = R0_ZERO && (codeQ == CODE_R0);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      codeQ      <= '0;
      dataQ      <= '0;
      errPend    <= 1'b0;
      rin_onehot <= '0;
      ld_done    <= 1'b0;
      ld_err     <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (ld_valid) begin
            codeQ   <= ld_code;
            dataQ   <= bus_in;
            errPend <= 1'b0;
          end
        end
        ST_LATCH: begin
          rin_onehot <= dropWrite ? '0 : decOnehot;
          errPend    <= !decInRange;
        end
        ST_WRITE: begin
          rin_onehot <= '0;
          ld_done    <= 1'b1;
          ld_err     <= errPend;
        end
        default: ;
      endcase
    end
  end

  // The registered strobe is the load enable; at most one bit is ever set.
  for (genvar i = 0; i < NUM_DEST; i++) begin : gBank
    logic [DATA_W-1:0] q;
    always_ff @(posedge clock) begin
      if (!clear_n)                               q <= '0;
      else if (state == ST_WRITE && rin_onehot[i]) q <= dataQ;
    end
    assign regs_flat[i*DATA_W +: DATA_W] = q;
  end

endmodule
